// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU MEM stage and a debug requester.
// Serialises accesses, stalls the CPU while its access is pending and returns read data.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int CPU_BURST = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [2:0]        cpu_amp,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [2:0]        dbg_amp,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_amp,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              BW        = $clog2(CPU_BURST + 1);
  localparam logic [BW-1:0]   BURST_MAX = BW'(CPU_BURST);
  localparam logic [1:0]      WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]        mem_amp_q, mem_amp_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wr_q, wr_d;
  logic              owner_dbg_q, owner_dbg_d;
  logic              last_dbg_q, last_dbg_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [1:0]        wait_q, wait_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic cpu_req_s;
  logic grant_cpu_s;
  logic grant_dbg_s;
  logic cpu_done_s;
  logic rd_done_s;

  assign cpu_req_s  = cpu_rd | cpu_wr;
  assign cpu_done_s = (state_q == S_DONE) && !owner_dbg_q;
  assign rd_done_s  = (state_q == S_DONE) && !wr_q;

  assign cpu_stall = cpu_req_s & ~cpu_done_s;
  assign cpu_rdata = (rd_done_s && !owner_dbg_q) ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata = (rd_done_s && owner_dbg_q) ? mem_rdata : dbg_rdata_q;
  assign dbg_ack   = dbg_ack_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_amp   = mem_amp_q;
  assign mem_wdata = mem_wdata_q;

  // Round-robin arbitration, biased toward the CPU for up to CPU_BURST grants in a row.
  always_comb begin
    grant_cpu_s = 1'b0;
    grant_dbg_s = 1'b0;
    if (state_q == S_IDLE) begin
      if (cpu_req_s && dbg_req) begin
        if (last_dbg_q || (burst_q < BURST_MAX)) begin
          grant_cpu_s = 1'b1;
        end else begin
          grant_dbg_s = 1'b1;
        end
      end else if (cpu_req_s) begin
        grant_cpu_s = 1'b1;
      end else if (dbg_req) begin
        grant_dbg_s = 1'b1;
      end else begin
        grant_cpu_s = 1'b0;
      end
    end else begin
      grant_dbg_s = 1'b0;
    end
  end

  // Next-state, winner-field latch, completion and read-capture logic.
  always_comb begin
    state_d     = state_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_amp_d   = mem_amp_q;
    mem_wdata_d = mem_wdata_q;
    wr_d        = wr_q;
    owner_dbg_d = owner_dbg_q;
    last_dbg_d  = last_dbg_q;
    wait_d      = wait_q;
    dbg_ack_d   = dbg_ack_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;

    if (!dbg_req || grant_dbg_s) begin
      burst_d = '0;
    end else if (grant_cpu_s && (burst_q != BURST_MAX)) begin
      burst_d = burst_q + BW'(1);
    end else begin
      burst_d = burst_q;
    end

    case (state_q)
      S_IDLE: begin
        if (grant_cpu_s) begin
          state_d     = S_ISSUE;
          mem_addr_d  = cpu_addr;
          mem_amp_d   = cpu_amp;
          mem_wdata_d = cpu_wdata;
          wr_d        = cpu_wr;
          mem_we_d    = cpu_wr;
          mem_re_d    = ~cpu_wr;
          owner_dbg_d = 1'b0;
          last_dbg_d  = 1'b0;
        end else if (grant_dbg_s) begin
          state_d     = S_ISSUE;
          mem_addr_d  = dbg_addr;
          mem_amp_d   = dbg_amp;
          mem_wdata_d = dbg_wdata;
          wr_d        = dbg_we;
          mem_we_d    = dbg_we;
          mem_re_d    = ~dbg_we;
          owner_dbg_d = 1'b1;
          last_dbg_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        mem_re_d = 1'b0;
        mem_we_d = 1'b0;
        if (!wr_q && (RD_LAT > 1)) begin
          state_d = S_WAIT;
          wait_d  = WAIT_INIT;
        end else begin
          state_d   = S_DONE;
          dbg_ack_d = owner_dbg_q;
        end
      end
      S_WAIT: begin
        if (wait_q == 2'd0) begin
          state_d   = S_DONE;
          dbg_ack_d = owner_dbg_q;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        dbg_ack_d = 1'b0;
        if (!wr_q && owner_dbg_q) begin
          dbg_rdata_d = mem_rdata;
        end else if (!wr_q) begin
          cpu_rdata_d = mem_rdata;
        end else begin
          cpu_rdata_d = cpu_rdata_q;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_re_d  = 1'b0;
        mem_we_d  = 1'b0;
        dbg_ack_d = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any access in flight and makes the CPU win the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_amp_q   <= 3'd0;
      mem_wdata_q <= '0;
      wr_q        <= 1'b0;
      owner_dbg_q <= 1'b0;
      last_dbg_q  <= 1'b1;
      burst_q     <= '0;
      wait_q      <= 2'd0;
      dbg_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_amp_q   <= mem_amp_d;
      mem_wdata_q <= mem_wdata_d;
      wr_q        <= wr_d;
      owner_dbg_q <= owner_dbg_d;
      last_dbg_q  <= last_dbg_d;
      burst_q     <= burst_d;
      wait_q      <= wait_d;
      dbg_ack_q   <= dbg_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

endmodule
